// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths and types for the instruction prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_WIDTH   = 4;
    localparam int ISSUE_WIDTH   = 3;
    localparam int c_INSTR_WIDTH = 16;
    localparam int c_ADDR_WIDTH  = 15;

    typedef logic [c_INSTR_WIDTH-1:0] instr_t;
    typedef logic [c_ADDR_WIDTH-1:0]  iaddr_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_mem
// Description : Circular instruction store, 4-wide write, 3-wide async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = c_INSTR_WIDTH,
    parameter int DEPTH       = 16
)(
    input  logic                                    clk,
    input  logic                                    i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]                i_wr_ptr,
    input  logic [FETCH_WIDTH-1:0][INSTR_WIDTH-1:0] i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]                i_rd_ptr,
    output logic [ISSUE_WIDTH-1:0][INSTR_WIDTH-1:0] o_rd_data
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

    // Storage is never reset: the owner masks stale entries with its count.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                r_mem[i_wr_ptr + c_PTR_W'(k)] <= i_wr_data[k];
            end
        end
    end

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_rd
        assign o_rd_data[k] = r_mem[i_rd_ptr + c_PTR_W'(k)];
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch queue between quad-banked ROMs and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = c_INSTR_WIDTH,
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int DEPTH       = 16
)(
    input  logic                   clk,
    input  logic                   resetN,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_q0,
    input  logic [INSTR_WIDTH-1:0] rom_q1,
    input  logic [INSTR_WIDTH-1:0] rom_q2,
    input  logic [INSTR_WIDTH-1:0] rom_q3,
    output logic [INSTR_WIDTH-1:0] inst_0,
    output logic [INSTR_WIDTH-1:0] inst_1,
    output logic [INSTR_WIDTH-1:0] inst_2,
    output logic [ADDR_WIDTH-1:0]  pc_0,
    output logic [1:0]             avail,
    input  logic [1:0]             consume,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   protocol_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OCC_W = c_PTR_W + 2;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_head_pc;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_inflight;
    logic                  r_protocol_err;

    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_fetch_now;
    logic                  w_write;
    logic [1:0]            w_avail;
    logic [1:0]            w_eff;
    logic [c_CNT_W-1:0]    w_count_next;
    logic [ISSUE_WIDTH-1:0][INSTR_WIDTH-1:0] w_rd_data;
    logic [ISSUE_WIDTH-1:0][INSTR_WIDTH-1:0] w_inst;

    // Reserve room for the queued words, the in-flight block and the new one.
    assign w_occ = c_OCC_W'(r_count)
                 + (r_inflight ? c_OCC_W'(2 * FETCH_WIDTH) : c_OCC_W'(FETCH_WIDTH));
    assign w_fetch_now = redirect_valid | (w_occ <= c_OCC_W'(DEPTH));
    assign rom_addr    = redirect_valid ? redirect_addr : r_fetch_pc;
    assign w_write     = r_inflight & ~redirect_valid;

    assign w_avail = (r_count >= c_CNT_W'(ISSUE_WIDTH)) ? 2'(ISSUE_WIDTH) : r_count[1:0];
    assign w_eff   = (consume > w_avail) ? w_avail : consume;
    assign w_count_next = r_count
                        + (w_write ? c_CNT_W'(FETCH_WIDTH) : '0)
                        - c_CNT_W'(w_eff);

    fetch_queue_mem #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_write),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data ({rom_q3, rom_q2, rom_q1, rom_q0}),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_inst
        assign w_inst[k] = (r_count > c_CNT_W'(k)) ? w_rd_data[k] : '0;
    end

    assign inst_0       = w_inst[0];
    assign inst_1       = w_inst[1];
    assign inst_2       = w_inst[2];
    assign pc_0         = r_head_pc;
    assign avail        = w_avail;
    assign protocol_err = r_protocol_err;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_fetch_pc     <= '0;
            r_head_pc      <= '0;
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_inflight     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_inflight <= w_fetch_now;
            if (w_fetch_now) begin
                r_fetch_pc <= rom_addr + ADDR_WIDTH'(FETCH_WIDTH);
            end
            // A redirect drops the arriving response and ignores consume.
            if (redirect_valid) begin
                r_count   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_head_pc <= redirect_addr;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(FETCH_WIDTH);
                end
                r_rd_ptr  <= r_rd_ptr + c_PTR_W'(w_eff);
                r_count   <= w_count_next;
                r_head_pc <= r_head_pc + ADDR_WIDTH'(w_eff);
                if (consume > w_avail) begin
                    r_protocol_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetN;
    iaddr_t     rom_addr;
    instr_t     rom_q0, rom_q1, rom_q2, rom_q3;
    instr_t     inst_0, inst_1, inst_2;
    iaddr_t     pc_0;
    logic [1:0] avail;
    logic [1:0] consume;
    logic       redirect_valid;
    iaddr_t     redirect_addr;
    logic       protocol_err;

    always #5 clk = ~clk;

    fetch_queue #(
        .INSTR_WIDTH (16),
        .ADDR_WIDTH  (15),
        .DEPTH       (DEPTH)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .rom_addr       (rom_addr),
        .rom_q0         (rom_q0),
        .rom_q1         (rom_q1),
        .rom_q2         (rom_q2),
        .rom_q3         (rom_q3),
        .inst_0         (inst_0),
        .inst_1         (inst_1),
        .inst_2         (inst_2),
        .pc_0           (pc_0),
        .avail          (avail),
        .consume        (consume),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .protocol_err   (protocol_err)
    );

    // ROM image: word at address a holds a; data returns one cycle after the address.
    function automatic instr_t rom_fn(input iaddr_t a);
        return instr_t'(a);
    endfunction

    iaddr_t rom_base;
    always @(posedge clk) rom_base <= rom_addr;
    assign rom_q0 = rom_fn(rom_base);
    assign rom_q1 = rom_fn(rom_base + 15'd1);
    assign rom_q2 = rom_fn(rom_base + 15'd2);
    assign rom_q3 = rom_fn(rom_base + 15'd3);

    // Reference model: the queue holds the addresses of buffered instructions.
    iaddr_t m_q[$];
    iaddr_t m_head, m_fetch_pc, m_inflight_addr;
    bit     m_inflight, m_err;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    function automatic int m_avail();
        return (m_q.size() > 3) ? 3 : m_q.size();
    endfunction

    function automatic instr_t m_inst(input int k);
        return (k < m_q.size()) ? rom_fn(m_q[k]) : instr_t'(0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_head = '0; m_fetch_pc = '0; m_inflight_addr = '0;
        m_inflight = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_model();
        chk("avail",    32'(avail),        32'(m_avail()));
        chk("inst_0",   32'(inst_0),       32'(m_inst(0)));
        chk("inst_1",   32'(inst_1),       32'(m_inst(1)));
        chk("inst_2",   32'(inst_2),       32'(m_inst(2)));
        chk("pc_0",     32'(pc_0),         32'(m_head));
        chk("rom_addr", 32'(rom_addr),     32'(redirect_valid ? redirect_addr : m_fetch_pc));
        chk("perr",     32'(protocol_err), 32'(m_err));
    endtask

    task automatic model_step(input int c, input bit rv, input iaddr_t ra);
        bit     fetch_now;
        iaddr_t base;
        int     av, eff;
        fetch_now = rv || (m_q.size() + 4 * int'(m_inflight) + 4 <= DEPTH);
        base      = rv ? ra : m_fetch_pc;
        if (rv) begin
            m_q.delete();
            m_head = ra;
        end else begin
            av  = m_avail();
            eff = (c > av) ? av : c;
            if (c > av) m_err = 1'b1;
            repeat (eff) void'(m_q.pop_front());
            m_head = m_head + iaddr_t'(eff);
            if (m_inflight)
                for (int k = 0; k < 4; k++) m_q.push_back(m_inflight_addr + iaddr_t'(k));
        end
        if (fetch_now) begin
            m_fetch_pc      = base + 15'd4;
            m_inflight_addr = base;
        end
        m_inflight = fetch_now;
    endtask

    task automatic drive(input logic [1:0] c, input logic rv, input iaddr_t ra);
        consume = c; redirect_valid = rv; redirect_addr = ra;
        #1;
    endtask

    task automatic advance();
        model_step(int'(consume), redirect_valid, redirect_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic [1:0] c, input logic rv, input iaddr_t ra);
        drive(c, rv, ra);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        resetN = 1'b0; consume = '0; redirect_valid = 1'b0; redirect_addr = '0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] c;
        logic       rv;
        iaddr_t     ra;
        logic [1:0] e_avail;
        iaddr_t     e_pc;
        instr_t     e_i0;
        instr_t     e_i2;
        iaddr_t     e_rom;
        logic       e_err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // One row per cycle starting at the first cycle after reset release.
        tbl[0]  = '{2'd0, 1'b0, 15'h0,   2'd0, 15'h0,   16'h0,   16'h0,   15'h0,   1'b0};
        tbl[1]  = '{2'd0, 1'b0, 15'h0,   2'd0, 15'h0,   16'h0,   16'h0,   15'h4,   1'b0};
        tbl[2]  = '{2'd0, 1'b0, 15'h0,   2'd3, 15'h0,   16'h0,   16'h2,   15'h8,   1'b0};
        tbl[3]  = '{2'd3, 1'b0, 15'h0,   2'd3, 15'h0,   16'h0,   16'h2,   15'hC,   1'b0};
        tbl[4]  = '{2'd3, 1'b0, 15'h0,   2'd3, 15'h3,   16'h3,   16'h5,   15'h10,  1'b0};
        tbl[5]  = '{2'd3, 1'b0, 15'h0,   2'd3, 15'h6,   16'h6,   16'h8,   15'h10,  1'b0};
        tbl[6]  = '{2'd1, 1'b0, 15'h0,   2'd3, 15'h9,   16'h9,   16'hB,   15'h14,  1'b0};
        tbl[7]  = '{2'd3, 1'b1, 15'h100, 2'd3, 15'hA,   16'hA,   16'hC,   15'h100, 1'b0};
        tbl[8]  = '{2'd0, 1'b0, 15'h0,   2'd0, 15'h100, 16'h0,   16'h0,   15'h104, 1'b0};
        tbl[9]  = '{2'd2, 1'b0, 15'h0,   2'd3, 15'h100, 16'h100, 16'h102, 15'h108, 1'b0};
        tbl[10] = '{2'd0, 1'b0, 15'h0,   2'd3, 15'h102, 16'h102, 16'h104, 15'h10C, 1'b0};

        resetN = 1'b0; consume = '0; redirect_valid = 1'b0; redirect_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avail", 32'(avail),    32'd0);
        chk("rst_pc",    32'(pc_0),     32'd0);
        chk("rst_rom",   32'(rom_addr), 32'd0);
        chk("rst_inst0", 32'(inst_0),   32'd0);
        resetN = 1'b1;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].c, tbl[i].rv, tbl[i].ra);
            chk($sformatf("v%0d_avail", i), 32'(avail),        32'(tbl[i].e_avail));
            chk($sformatf("v%0d_pc",    i), 32'(pc_0),         32'(tbl[i].e_pc));
            chk($sformatf("v%0d_i0",    i), 32'(inst_0),       32'(tbl[i].e_i0));
            chk($sformatf("v%0d_i2",    i), 32'(inst_2),       32'(tbl[i].e_i2));
            chk($sformatf("v%0d_rom",   i), 32'(rom_addr),     32'(tbl[i].e_rom));
            chk($sformatf("v%0d_err",   i), 32'(protocol_err), 32'(tbl[i].e_err));
            advance();
        end

        // Saturation with no consumption: queue fills to DEPTH and fetch stops.
        do_reset();
        repeat (12) cycle(2'd0, 1'b0, '0);
        drive(2'd0, 1'b0, '0);
        chk("sat_rom",   32'(rom_addr), 32'h10);
        chk("sat_avail", 32'(avail),    32'd3);
        chk("sat_inst1", 32'(inst_1),   32'd1);
        advance();

        // Redirect near the top of the address space.
        cycle(2'd0, 1'b1, 15'h7FFE);
        cycle(2'd0, 1'b0, '0);
        drive(2'd2, 1'b0, '0);
        chk("wrap_pc",    32'(pc_0),   32'h7FFE);
        chk("wrap_inst0", 32'(inst_0), 32'h7FFE);
        chk("wrap_inst1", 32'(inst_1), 32'h7FFF);
        chk("wrap_inst2", 32'(inst_2), 32'h0000);
        check_model();
        advance();
        drive(2'd0, 1'b0, '0);
        chk("wrap_pc2",   32'(pc_0),   32'h0000);
        chk("wrap_inst1b", 32'(inst_1), 32'h0001);
        advance();

        // Over-consumption while the queue is empty sets the sticky error.
        cycle(2'd0, 1'b1, 15'h0123);
        drive(2'd3, 1'b0, '0);
        chk("perr_avail0", 32'(avail),        32'd0);
        chk("perr_before", 32'(protocol_err), 32'd0);
        advance();
        drive(2'd0, 1'b0, '0);
        chk("perr_set",   32'(protocol_err), 32'd1);
        chk("perr_pc",    32'(pc_0),         32'h0123);
        chk("perr_avail", 32'(avail),        32'd3);
        advance();
        repeat (3) cycle(2'd0, 1'b0, '0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       rv;
            iaddr_t     ra;
            rv = ($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 3) == 0) ? iaddr_t'(15'h7FFC + 15'($urandom_range(0, 7)))
                                             : iaddr_t'($urandom);
            cycle(2'($urandom_range(0, 3)), rv, ra);
        end

        // Asynchronous reset in the middle of a fill clears state immediately.
        do_reset();
        repeat (3) cycle(2'd0, 1'b0, '0);
        drive(2'd0, 1'b0, '0);
        resetN = 1'b0;
        #1;
        chk("mid_rst_avail", 32'(avail),        32'd0);
        chk("mid_rst_pc",    32'(pc_0),         32'd0);
        chk("mid_rst_rom",   32'(rom_addr),     32'd0);
        chk("mid_rst_inst0", 32'(inst_0),       32'd0);
        chk("mid_rst_err",   32'(protocol_err), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        repeat (4) cycle(2'd0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the quad-banked instruction ROMs and the superscalar `cpu` decode stage. Each cycle it can issue one ROM fetch of four consecutive instructions, buffers the returned words in a circular queue, and presents up to three in-order instructions plus the address of the first to the CPU. The CPU reports how many it consumed and may redirect fetch on a taken jump, which flushes the queue.

## Interface
- `INSTR_WIDTH`, 16: instruction word width.
- `ADDR_WIDTH`, 15: instruction address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DEPTH`, 16: queue entries; power of two, ≥ 8.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `resetN`  in  1: reset, asynchronous, active-low.
- `rom_addr`  out  ADDR_WIDTH: fetch base address; the ROM banks return words at `rom_addr`+0..3 one cycle later.
- `rom_q0`..`rom_q3`  in  INSTR_WIDTH each: ROM data for base+0..3.
- `inst_0`..`inst_2`  out  INSTR_WIDTH each: queue head, head+1, head+2.
- `pc_0`  out  ADDR_WIDTH: address of `inst_0`.
- `avail`  out  2: number of valid instructions on `inst_0..2`, 0–3.
- `consume`  in  2: instructions the CPU accepts this cycle.
- `redirect_valid`  in  1: taken jump; flush and refetch.
- `redirect_addr`  in  ADDR_WIDTH: jump target.
- `protocol_err`  out  1: sticky flag, set when `consume` > `avail`.

## Operation
- State: `fetch_pc`, `head_pc`, `count` (0..DEPTH), read and write pointers, `inflight` (1 bit).
- Fetch issue: `fetch_now` = `redirect_valid` OR (`count` + 4·`inflight` + 4 ≤ DEPTH).
- `rom_addr` is combinational: `redirect_addr` when `redirect_valid`, else `fetch_pc`.
- When `fetch_now` is high, `fetch_pc` ← `rom_addr`+4 and `inflight` ← 1. Otherwise `inflight` ← 0.
- Response: if `inflight` is high and `redirect_valid` is low, write `rom_q0..3` into four consecutive entries at the write pointer. Space is guaranteed by the issue rule.
- Read: `inst_k` = entry[rd_ptr+k] if k < `count`, else 0. `avail` = min(`count`, 3). `pc_0` = `head_pc`.
- Consume: `eff` = min(`consume`, `avail`). Pointer, `count` and `head_pc` all advance by `eff`.
- Count update: `count_next` = `count` + 4·write − `eff`.
- Redirect: `count` ← 0, pointers ← 0, `head_pc` ← `redirect_addr`. The response arriving in the same cycle is dropped, and `consume` is ignored.
- Error: if `consume` > `avail` and no redirect, `protocol_err` ← 1. It clears only on reset.
- Wrap: pointers wrap modulo DEPTH. `fetch_pc` and `head_pc` wrap modulo 2^ADDR_WIDTH, so a fetch at 0x7FFE returns 0x7FFE, 0x7FFF, 0x0000, 0x0001.

## Timing
- Reset values: `fetch_pc`=0, `head_pc`=0, `count`=0, `inflight`=0, `protocol_err`=0. Outputs follow: `avail`=0, `inst_0..2`=0, `pc_0`=0, `rom_addr`=0.
- Reset mid-operation discards all queue contents and any in-flight response immediately.
- First fetch issues in the first cycle after `resetN` rises (cycle C). Data lands at the end of C+1, giving `avail`=3 with `pc_0`=0 in cycle C+2.
- Redirect in cycle N gives `avail`=0 in N+1 and `avail`=3 with `pc_0`=target in N+2. Jump penalty is two cycles.
- Steady state: consuming 3 per cycle with DEPTH=16 never starves after the initial fill.
- All outputs except `rom_addr` are registered-state functions with no input-to-output combinational path.

## Structure
- Package `fetch_pkg`:
  - `FETCH_WIDTH`=4 and `ISSUE_WIDTH`=3.
  - typedef `instr_t` (INSTR_WIDTH bits) and `iaddr_t` (ADDR_WIDTH bits).
- Sub-module `fetch_queue_mem`: circular array with one 4-wide write port and a 3-wide combinational read at the read pointer. Pointer and count logic stays in `fetch_queue`.
- Top-level integration: `cpu_garage` drives the four ROM address inputs from `rom_addr`+0..3.

## Test plan
- Reset release with ROM[i]=i and `consume`=0: `avail`=3, `inst_0..2`=0,1,2 and `pc_0`=0 at C+2. `count` saturates at 16 and fetch stops; `rom_addr` holds 16.
- `consume`=3 every cycle from C+2: `pc_0` sequence 0,3,6,9…, each `inst_k`=`pc_0`+k, never `avail`<3 after the fill.
- Redirect to 0x0100 while `inflight`=1: the stale response is dropped, `avail`=0 next cycle, then `inst_0`=ROM[0x100] with `pc_0`=0x100.
- Redirect with `consume`=3 in the same cycle: `consume` ignored, `protocol_err` stays 0, `head_pc`=target.
- Redirect to 0x7FFE: instructions for 0x7FFE, 0x7FFF, 0x0000 appear in order, and `pc_0` wraps to 0x0000.
- `consume`=3 while `avail`=1: `protocol_err`=1 sticky, `count` decremented by 1 only. `resetN` low mid-fill clears all state the same cycle.
